// File: rtl/fsm_result_pkg.sv
// Shared constants and helpers for the result-producing FSM stage and its collect FIFO.
package fsm_result_pkg;

    localparam int RESULT_W   = 32;
    localparam int DROP_CNT_W = 16;

    localparam logic [RESULT_W-1:0] RES_WORK = 32'hFFFF_FFFF;
    localparam logic [RESULT_W-1:0] RES_DONE = 32'hAAAA_AAAA;

    typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

    // Saturating increment so a long-stuck upstream never wraps the drop counter to zero.
    function automatic drop_cnt_t sat_inc(input drop_cnt_t v);
        return (v == '1) ? v : v + drop_cnt_t'(1);
    endfunction

endpackage

// File: rtl/result_collect_fifo_if.sv
// Upstream push, downstream valid/ready drain and status signals of the result collect FIFO.
import fsm_result_pkg::*;

interface result_collect_fifo_if #(
    parameter int WIDTH = RESULT_W,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  in_valid;
    logic [WIDTH-1:0]      in_data;
    logic                  almfull;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic                  out_ready;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  clear_overflow;
    logic [DROP_CNT_W-1:0] drop_count;

    modport master (
        output in_valid, in_data, out_ready, clear_overflow,
        input  almfull, out_valid, out_data, count, overflow, drop_count
    );

    modport slave (
        input  in_valid, in_data, out_ready, clear_overflow,
        output almfull, out_valid, out_data, count, overflow, drop_count
    );

endinterface

// File: rtl/result_fifo_mem.sv
// DEPTH x WIDTH register-array storage: synchronous write, asynchronous read, never cleared.
module result_fifo_mem #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/result_collect_fifo.sv
// First-word-fall-through sink for FSM results: almfull back-pressure from the count
// register, sticky overflow and saturating drop counter for a stuck-high upstream valid.
import fsm_result_pkg::*;

module result_collect_fifo #(
    parameter int WIDTH     = RESULT_W,
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    result_collect_fifo_if.slave  fifo_bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_count;
    logic             r_overflow;
    drop_cnt_t        r_drop_count;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_wr_en;
    logic             w_drop;
    logic [WIDTH-1:0] w_rd_data;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A pop frees a slot on the same edge, so a push into a full FIFO is still accepted then.
    assign w_pop   = !w_empty && fifo_bus.out_ready;
    assign w_wr_en = fifo_bus.in_valid && (!w_full || w_pop);
    assign w_drop  = fifo_bus.in_valid && w_full && !w_pop;

    result_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (fifo_bus.in_data),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else begin
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + PW'(1);
                2'b01:   r_count <= r_count - PW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Clear has priority so software never loses a clear to a coincident drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (fifo_bus.clear_overflow) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow   <= 1'b1;
            r_drop_count <= sat_inc(r_drop_count);
        end
    end

    assign fifo_bus.count      = r_count;
    assign fifo_bus.almfull    = (r_count >= AF_LEVEL);
    assign fifo_bus.out_valid  = !w_empty;
    assign fifo_bus.out_data   = w_empty ? '0 : w_rd_data;
    assign fifo_bus.overflow   = r_overflow;
    assign fifo_bus.drop_count = r_drop_count;

endmodule

// File: tb/tb_result_collect_fifo.sv
// Directed and randomized stimulus against a queue-based reference of the collect FIFO.
import fsm_result_pkg::*;

module tb_result_collect_fifo;

    localparam int DEPTH     = 8;
    localparam int AF_MARGIN = 2;

    logic clk;
    logic reset_n;

    int compared;
    int mismatched;

    logic [31:0] mq [$];
    bit          m_ovf;
    int unsigned m_drops;

    result_collect_fifo_if #(.WIDTH(32), .DEPTH(DEPTH)) bus ();

    result_collect_fifo #(
        .WIDTH     (32),
        .DEPTH     (DEPTH),
        .AF_MARGIN (AF_MARGIN)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .fifo_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        logic [31:0] exp_data;
        exp_data = (mq.size() > 0) ? mq[0] : 32'h0;
        chk({ctx, ".count"},      32'(bus.count),      32'(mq.size()));
        chk({ctx, ".out_valid"},  32'(bus.out_valid),  32'(mq.size() > 0));
        chk({ctx, ".out_data"},   bus.out_data,        exp_data);
        chk({ctx, ".almfull"},    32'(bus.almfull),    32'(mq.size() >= DEPTH - AF_MARGIN));
        chk({ctx, ".overflow"},   32'(bus.overflow),   32'(m_ovf));
        chk({ctx, ".drop_count"}, 32'(bus.drop_count), m_drops);
    endtask

    task automatic model_edge(input bit v, input logic [31:0] d, input bit rdy, input bit clr);
        bit popped;
        bit dropped;
        popped  = (mq.size() > 0) && rdy;
        dropped = 1'b0;
        if (v && mq.size() == DEPTH && !popped) dropped = 1'b1;
        if (popped) void'(mq.pop_front());
        if (v && !dropped) mq.push_back(d);
        if (clr) begin
            m_ovf   = 1'b0;
            m_drops = 0;
        end else if (dropped) begin
            m_ovf = 1'b1;
            if (m_drops < 32'hFFFF) m_drops++;
        end
    endtask

    task automatic step(input bit v, input logic [31:0] d, input bit rdy, input bit clr,
                        input string ctx);
        bus.in_valid       = v;
        bus.in_data        = d;
        bus.out_ready      = rdy;
        bus.clear_overflow = clr;
        @(posedge clk);
        model_edge(v, d, rdy, clr);
        #1;
        check_all(ctx);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        m_ovf      = 1'b0;
        m_drops    = 0;
        reset_n            = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_data        = '0;
        bus.out_ready      = 1'b0;
        bus.clear_overflow = 1'b0;
        #3;
        check_all("por");
        #9 reset_n = 1'b1;

        // Asynchronous reset with five words held
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0, "rst_fill");
        chk("rst_pre_count", 32'(bus.count), 32'd5);
        bus.in_valid = 1'b0;
        #2 reset_n = 1'b0;
        mq.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
        #1;
        check_all("rst_async");
        #1 reset_n = 1'b1;

        // Single word, then pop
        step(1'b1, RES_DONE, 1'b0, 1'b0, "single_push");
        chk("single_data", bus.out_data, 32'hAAAA_AAAA);
        chk("single_count", 32'(bus.count), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0, "single_pop");
        chk("single_empty", 32'(bus.count), 32'd0);

        // Empty + push + ready: no bypass
        step(1'b1, RES_WORK, 1'b1, 1'b0, "nobypass_push");
        step(1'b0, '0, 1'b1, 1'b0, "nobypass_pop");

        // almfull threshold
        for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b0, 1'b0, "af_fill");
        chk("af_set", 32'(bus.almfull), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0, "af_pop");
        chk("af_clear", 32'(bus.almfull), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, "af_drain");

        // Overflow: 10 pushes into 8 entries, then drain in order
        for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b0, 1'b0, "ovf_fill");
        chk("ovf_count", 32'(bus.count), 32'd8);
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        chk("ovf_drops", 32'(bus.drop_count), 32'd2);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0, "ovf_drain");

        // Full with push and pop together
        for (int i = 0; i < 8; i++) step(1'b1, $urandom, 1'b0, 1'b0, "full_fill");
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b1, 1'b0, "full_pushpop");
        chk("full_pp_count", 32'(bus.count), 32'd8);
        chk("full_pp_drops", 32'(bus.drop_count), 32'd2);

        // Clear coincident with a drop
        step(1'b1, $urandom, 1'b0, 1'b0, "drop_more");
        step(1'b1, $urandom, 1'b0, 1'b1, "clr_vs_drop");
        chk("clr_ovf", 32'(bus.overflow), 32'd0);
        chk("clr_drops", 32'(bus.drop_count), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0, "clr_drain");

        // Pointer wrap with consumer always ready
        for (int i = 0; i < 20; i++) begin
            step(1'b1, $urandom, 1'b1, 1'b0, "wrap");
            chk("wrap_count_le1", 32'(bus.count <= 1), 32'd1);
        end
        step(1'b0, '0, 1'b1, 1'b0, "wrap_tail");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 3, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
